// File: rtl/seg_scan_if.sv
// Display-data bundle between a digit source and the multiplexed
// seven-segment scanner.
interface seg_scan_if #(
  parameter int DIGITS = 4
) ();
  logic [4*DIGITS-1:0] digits;
  logic [DIGITS-1:0]   dp_mask;
  logic                blank_lz;
  logic [7:0]          seg_n;
  logic [DIGITS-1:0]   an_n;
  logic                frame;

  modport master (
    output digits, dp_mask, blank_lz,
    input  seg_n, an_n, frame
  );

  modport slave (
    input  digits, dp_mask, blank_lz,
    output seg_n, an_n, frame
  );
endinterface

// File: rtl/seg_scan.sv
// Time-multiplexed seven-segment scanner with a per-frame input snapshot,
// dead-time anti-ghosting and optional leading-zero blanking.
module seg_scan #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000,
  parameter int DEAD     = 500
) (
  input  logic       clk,
  input  logic       reset,
  seg_scan_if.slave  bus
);

  localparam int TW = $clog2(SCAN_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [TW-1:0]       tick_q, tick_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0] snap_digits_q, snap_digits_d;
  logic [DIGITS-1:0]   snap_dp_q, snap_dp_d;
  logic                snap_blz_q, snap_blz_d;
  logic [7:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                frame_q, frame_d;

  logic                load;
  logic [DIGITS-1:0]   blank;
  logic                zero_above;
  logic [3:0]          cur_val;

  function automatic logic [6:0] pattern(input logic [3:0] v);
    case (v)
      4'h0: pattern = 7'h3F;
      4'h1: pattern = 7'h06;
      4'h2: pattern = 7'h5B;
      4'h3: pattern = 7'h4F;
      4'h4: pattern = 7'h66;
      4'h5: pattern = 7'h6D;
      4'h6: pattern = 7'h7D;
      4'h7: pattern = 7'h07;
      4'h8: pattern = 7'h7F;
      4'h9: pattern = 7'h6F;
      4'hA: pattern = 7'h77;
      4'hB: pattern = 7'h7C;
      4'hC: pattern = 7'h39;
      4'hD: pattern = 7'h5E;
      4'hE: pattern = 7'h79;
      default: pattern = 7'h71;
    endcase
  endfunction

  // Scan position and snapshot capture.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first,
    // so no path through the ifs can leave a latch behind.
    load          = (tick_q == '0) && (idx_q == '0);
    tick_d        = tick_q + 1'b1;
    idx_d         = idx_q;
    snap_digits_d = snap_digits_q;
    snap_dp_d     = snap_dp_q;
    snap_blz_d    = snap_blz_q;
    frame_d       = load;

    if (tick_q == TW'(SCAN_DIV - 1)) begin
      tick_d = '0;
      idx_d  = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end

    if (load) begin
      snap_digits_d = bus.digits;
      snap_dp_d     = bus.dp_mask;
      snap_blz_d    = bus.blank_lz;
    end
  end

  // A digit is blank when it and everything to its left is zero; digit 0 always shows.
  always_comb begin
    blank      = '0;
    zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above && (snap_digits_q[4*i +: 4] == 4'd0);
      if (i != 0) blank[i] = snap_blz_q && zero_above;
    end
  end

  always_comb begin
    cur_val = snap_digits_q[4*idx_q +: 4];
    seg_d   = 8'hFF;
    an_d    = '1;
    if ((tick_q >= TW'(DEAD)) && !blank[idx_q]) begin
      an_d  = ~(DIGITS'(1) << idx_q);
      seg_d = {~snap_dp_q[idx_q], ~pattern(cur_val)};
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the values from before this edge.
    if (reset) begin
      tick_q        <= '0;
      idx_q         <= '0;
      snap_digits_q <= '0;
      snap_dp_q     <= '0;
      snap_blz_q    <= 1'b0;
      seg_q         <= 8'hFF;
      an_q          <= '1;
      frame_q       <= 1'b0;
    end else begin
      tick_q        <= tick_d;
      idx_q         <= idx_d;
      snap_digits_q <= snap_digits_d;
      snap_dp_q     <= snap_dp_d;
      snap_blz_q    <= snap_blz_d;
      seg_q         <= seg_d;
      an_q          <= an_d;
      frame_q       <= frame_d;
    end
  end

  assign bus.seg_n = seg_q;
  assign bus.an_n  = an_q;
  assign bus.frame = frame_q;

endmodule

// File: doc/seg_scan.md
SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 Parameter DIGITS, default 4, number of multiplexed digits (legal 1..8).
REQ-002 Parameter SCAN_DIV, default 50000, clocks per digit slot (legal >= DEAD+1).
REQ-003 Parameter DEAD, default 500, all-off clocks at the start of each slot to prevent ghosting (legal >= 1).
REQ-004 clk  input  1  rising-edge clock; single clock domain.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 digits  input  4*DIGITS  digit values; digit i = digits[4i+3:4i]; digit 0 is the least significant (rightmost); each digit is normally the counter output of one chained seg stage.
REQ-007 dp_mask  input  DIGITS  bit i = 1 lights the decimal point of digit i.
REQ-008 blank_lz  input  1  1 = leading-zero blanking enabled.
REQ-009 seg_n  output  8  active-low segments; [0]=a .. [6]=g, [7]=dp; registered.
REQ-010 an_n  output  DIGITS  active-low digit enables; registered; at most one bit low at any time.
REQ-011 frame  output  1  registered one-cycle pulse marking a snapshot load.

Function
REQ-012 Slot counter tick runs 0..SCAN_DIV-1 and increments every clock; at SCAN_DIV-1 it wraps to 0 and digit index idx advances; idx wraps from DIGITS-1 to 0.
REQ-013 Snapshot registers (digits, dp_mask, blank_lz) load in every cycle with tick==0 and idx==0, including the first cycle after reset; between loads, input changes have no effect (no tearing within a frame).
REQ-014 frame is 1 in the cycle after each snapshot load, otherwise 0.
REQ-015 Outputs are registered: seg_n/an_n in cycle t+1 are a function of tick, idx and snapshot in cycle t.
REQ-016 tick < DEAD: an_n all 1, seg_n = 8'hFF.
REQ-017 tick >= DEAD and digit idx not blanked: an_n bit idx = 0 (all others 1); seg_n[6:0] = ~pattern(value); seg_n[7] = ~dp_mask[idx].
REQ-018 Active-high pattern (g..a) for values 0..F: 3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71.
REQ-019 Blanking: with snapshot blank_lz=1, digit i (i>=1) is blanked when it and every more-significant digit are 0; digit 0 is never blanked.
REQ-020 Blanked digit: an_n all 1 and seg_n = 8'hFF for the whole slot, dp included; the slot keeps its full SCAN_DIV length.
REQ-021 Frame period = DIGITS*SCAN_DIV clocks exactly, independent of data or blanking.
REQ-022 Values A..F are displayed as hex; no error flag.

Reset
REQ-023 While reset=1 at a rising edge: tick=0, idx=0, snapshot digits=0, dp_mask=0, blank_lz=0, seg_n=8'hFF, an_n all 1, frame=0.
REQ-024 Reset asserted mid-slot or mid-frame takes effect at the next edge; scanning restarts at digit 0, tick 0, with a fresh snapshot in the first cycle after release.

Verification (DIGITS=4, SCAN_DIV=8, DEAD=2)
REQ-025 Reset release, digits=16'h1234, dp_mask=0, blank_lz=0 -> frame=1 one cycle after release; digit 0: 2 cycles an_n=4'hF, then 6 cycles an_n=4'b1110, seg_n=8'h99; digits 1..3 follow with 8'hB0, 8'hA4, 8'hF9 on an_n 1101, 1011, 0111; frame repeats every 32 cycles.
REQ-026 digits=16'h0070, blank_lz=1 -> digit 3 slot fully dark; digit 2 slot dark; digit 1 shows 8'hF8; digit 0 shows 8'hC0.
REQ-027 digits=16'h0000, blank_lz=1, dp_mask=4'b0001 -> only digit 0 lit, seg_n=8'h40; digits 1..3 dark.
REQ-028 digits changed from 16'h1234 to 16'h5678 during digit 2 slot -> digits 2 and 3 of the current frame still show 2 and 1; the next frame shows 8,7,6,5.
REQ-029 reset pulsed for 1 cycle during digit 2 slot -> outputs 8'hFF / 4'hF the next cycle, frame pulse one cycle after release, digit 0 slot restarts with DEAD=2 dark cycles.
REQ-030 Every cycle of all tests: an_n has at most one bit low; seg_n=8'hFF whenever an_n is all 1.
